// File: rtl/bram_capture_pkg.sv
// Shared types and helpers for the BRAM capture controller: FSM encoding,
// address-width helper and the legal RAM read latencies.
package bram_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2,
      ARMED   = 2'd3
   } cap_state_e;

   // RAM output modes: LOW_LATENCY returns data one cycle after addressing,
   // HIGH_PERFORMANCE adds the output register (regcea) for a second cycle.
   localparam int RD_LAT_LOW_LAT   = 1;
   localparam int RD_LAT_HIGH_PERF = 2;

   function automatic int clogb2(input int depth);
      int d;
      int n;
      d = depth;
      for (n = 0; d > 0; n++)
         d = d >> 1;
      return n;
   endfunction

endpackage

// File: rtl/bram_rd_valid_pipe.sv
// Read-valid shift register tracking RAM reads in flight; also produces the
// RAM output-register enable when the RAM runs with READ_LATENCY=2.
module bram_rd_valid_pipe
   import bram_capture_pkg::*;
#(
   parameter int READ_LATENCY = RD_LAT_HIGH_PERF
) (
   input  logic clk,
   input  logic rst,
   input  logic rd_fire,
   output logic rd_valid,
   output logic regcea
);

   // Stage 0 is the cycle the read sits on the RAM pins.
   logic [READ_LATENCY:0] vld_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_pipe <= '0;
      else
         vld_pipe <= {vld_pipe[READ_LATENCY-1:0], rd_fire};
   end

   assign rd_valid = vld_pipe[READ_LATENCY];

   generate
      if (READ_LATENCY == RD_LAT_HIGH_PERF) begin : g_hp
         assign regcea = vld_pipe[1];
      end else begin : g_ll
         assign regcea = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture-then-readback controller driving a single-port no-change BRAM.
// Optional CAPTURE_TRIGGER_EN adds i_trigger and an ARMED state before capture.
module bram_capture_ctrl
   import bram_capture_pkg::*;
#(
   parameter int RAM_WIDTH    = 18,
   parameter int RAM_DEPTH    = 1024,
   parameter int ADDR_W       = clogb2(RAM_DEPTH-1),
   parameter int READ_LATENCY = RD_LAT_HIGH_PERF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_run,
`ifdef CAPTURE_TRIGGER_EN
   input  logic                 i_trigger,
`endif
   input  logic                 i_sample_valid,
   input  logic [RAM_WIDTH-1:0] i_sample,
   input  logic                 i_rd_req,
   input  logic [ADDR_W-1:0]    i_rd_addr,
   output logic [RAM_WIDTH-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_busy,
   output logic                 o_full,
   output logic                 o_ram_ena,
   output logic                 o_ram_wea,
   output logic                 o_ram_regcea,
   output logic                 o_ram_rsta,
   output logic [ADDR_W-1:0]    o_ram_addr,
   output logic [RAM_WIDTH-1:0] o_ram_din,
   input  logic [RAM_WIDTH-1:0] i_ram_dout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH-1);

`ifdef CAPTURE_TRIGGER_EN
   localparam cap_state_e RUN_STATE = ARMED;
`else
   localparam cap_state_e RUN_STATE = CAPTURE;
`endif

   cap_state_e           state, state_nxt;
   logic [ADDR_W-1:0]    wr_ptr, wr_ptr_nxt;
   logic                 ena_nxt, wea_nxt, rd_fire;
   logic [ADDR_W-1:0]    addr_nxt;
   logic [RAM_WIDTH-1:0] din_nxt;

   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      ena_nxt    = 1'b0;
      wea_nxt    = 1'b0;
      addr_nxt   = o_ram_addr;
      din_nxt    = o_ram_din;
      rd_fire    = 1'b0;
      case (state)
         IDLE: begin
            if (i_run) begin
               state_nxt  = RUN_STATE;
               wr_ptr_nxt = '0;
            end
         end
`ifdef CAPTURE_TRIGGER_EN
         ARMED: begin
            // The triggering sample itself is the first one stored.
            if (i_trigger && i_sample_valid) begin
               ena_nxt    = 1'b1;
               wea_nxt    = 1'b1;
               addr_nxt   = wr_ptr;
               din_nxt    = i_sample;
               wr_ptr_nxt = wr_ptr + ADDR_W'(1);
               state_nxt  = (wr_ptr == LAST_ADDR) ? DONE : CAPTURE;
            end
         end
`endif
         CAPTURE: begin
            if (i_sample_valid) begin
               ena_nxt    = 1'b1;
               wea_nxt    = 1'b1;
               addr_nxt   = wr_ptr;
               din_nxt    = i_sample;
               wr_ptr_nxt = wr_ptr + ADDR_W'(1);
               if (wr_ptr == LAST_ADDR)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            // A restart takes priority; a read issued alongside it is dropped.
            if (i_run) begin
               state_nxt  = RUN_STATE;
               wr_ptr_nxt = '0;
            end else if (i_rd_req) begin
               ena_nxt  = 1'b1;
               addr_nxt = i_rd_addr;
               rd_fire  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         o_ram_ena  <= 1'b0;
         o_ram_wea  <= 1'b0;
         o_ram_rsta <= 1'b1;
         o_ram_addr <= '0;
         o_ram_din  <= '0;
         o_busy     <= 1'b0;
         o_full     <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         o_ram_ena  <= ena_nxt;
         o_ram_wea  <= wea_nxt;
         o_ram_rsta <= (state_nxt == IDLE);
         o_ram_addr <= addr_nxt;
         o_ram_din  <= din_nxt;
         o_busy     <= (state_nxt == CAPTURE) || (state_nxt == ARMED);
         o_full     <= (state_nxt == DONE);
      end
   end

   // Reads in flight keep draining after a restart; only reset discards them.
   bram_rd_valid_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .rd_fire  (rd_fire),
      .rd_valid (o_rd_valid),
      .regcea   (o_ram_regcea)
   );

   assign o_rd_data = i_ram_dout;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Scoreboard bench: two controllers (READ_LATENCY 2 and 1) share stimulus,
// each driving its own behavioural no-change RAM model.
module tb_bram_capture_ctrl;

   localparam int W  = 18;
   localparam int D  = 16;
   localparam int AW = 4;

   typedef struct { logic [AW-1:0] a; logic [W-1:0] d; int c; } wexp_t;
   typedef struct { logic [W-1:0] d; int c; } rexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          run = 1'b0, sv = 1'b0, rd_req = 1'b0;
   logic [W-1:0]  smp = '0;
   logic [AW-1:0] rd_addr = '0;
`ifdef CAPTURE_TRIGGER_EN
   logic          trig = 1'b1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wexp_t wq_a[$], wq_b[$];
   rexp_t rq_a[$], rq_b[$];
   wexp_t we_a, we_b;
   rexp_t re_a, re_b;

   // ---------------- DUT A: READ_LATENCY=2 ----------------
   logic [W-1:0]  rdata_a, din_a, dout_a, rdat_a;
   logic [AW-1:0] addr_a;
   logic          vld_a, busy_a, full_a, ena_a, wea_a, regcea_a, rsta_a;
   logic [W-1:0]  mem_a [D];

   bram_capture_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_W(AW), .READ_LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .i_run(run),
`ifdef CAPTURE_TRIGGER_EN
      .i_trigger(trig),
`endif
      .i_sample_valid(sv), .i_sample(smp), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
      .o_rd_data(rdata_a), .o_rd_valid(vld_a), .o_busy(busy_a), .o_full(full_a),
      .o_ram_ena(ena_a), .o_ram_wea(wea_a), .o_ram_regcea(regcea_a), .o_ram_rsta(rsta_a),
      .o_ram_addr(addr_a), .o_ram_din(din_a), .i_ram_dout(dout_a));

   always @(posedge clk)
      if (ena_a) begin
         if (wea_a) mem_a[addr_a] <= din_a;
         else       rdat_a <= mem_a[addr_a];
      end
   always @(posedge clk)
      if (rsta_a)        dout_a <= '0;
      else if (regcea_a) dout_a <= rdat_a;

   // ---------------- DUT B: READ_LATENCY=1 ----------------
   logic [W-1:0]  rdata_b, din_b, dout_b, rdat_b;
   logic [AW-1:0] addr_b;
   logic          vld_b, busy_b, full_b, ena_b, wea_b, regcea_b, rsta_b;
   logic [W-1:0]  mem_b [D];

   bram_capture_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_W(AW), .READ_LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .i_run(run),
`ifdef CAPTURE_TRIGGER_EN
      .i_trigger(trig),
`endif
      .i_sample_valid(sv), .i_sample(smp), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
      .o_rd_data(rdata_b), .o_rd_valid(vld_b), .o_busy(busy_b), .o_full(full_b),
      .o_ram_ena(ena_b), .o_ram_wea(wea_b), .o_ram_regcea(regcea_b), .o_ram_rsta(rsta_b),
      .o_ram_addr(addr_b), .o_ram_din(din_b), .i_ram_dout(dout_b));

   always @(posedge clk)
      if (ena_b) begin
         if (wea_b) mem_b[addr_b] <= din_b;
         else       rdat_b <= mem_b[addr_b];
      end
   assign dout_b = rdat_b;

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ena_a && wea_a) begin
         if (wq_a.size() == 0) chk("wr_a unexpected", 1, 0);
         else begin
            we_a = wq_a.pop_front();
            chk("wr_a addr", addr_a, we_a.a);
            chk("wr_a data", din_a, we_a.d);
            chk("wr_a cycle", cyc, we_a.c);
         end
      end
      if (ena_b && wea_b) begin
         if (wq_b.size() == 0) chk("wr_b unexpected", 1, 0);
         else begin
            we_b = wq_b.pop_front();
            chk("wr_b addr", addr_b, we_b.a);
            chk("wr_b data", din_b, we_b.d);
            chk("wr_b cycle", cyc, we_b.c);
         end
      end
   end

   logic rgc_prev_a = 1'b0, rgc_prev_b = 1'b0;
   always @(negedge clk) begin
      if (vld_a) begin
         if (rq_a.size() == 0) chk("rd_a unexpected", 1, 0);
         else begin
            re_a = rq_a.pop_front();
            chk("rd_a data", rdata_a, re_a.d);
            chk("rd_a cycle", cyc, re_a.c);
            chk("rd_a regcea lead", rgc_prev_a, 1);
         end
      end
      if (vld_b) begin
         if (rq_b.size() == 0) chk("rd_b unexpected", 1, 0);
         else begin
            re_b = rq_b.pop_front();
            chk("rd_b data", rdata_b, re_b.d);
            chk("rd_b cycle", cyc, re_b.c);
            chk("rd_b regcea", {regcea_b, rgc_prev_b}, 0);
         end
      end
      rgc_prev_a = regcea_a;
      rgc_prev_b = regcea_b;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic wr(input logic [W-1:0] v, input logic [AW-1:0] a);
      sv  = 1'b1;
      smp = v;
      wq_a.push_back('{a, v, cyc + 1});
      wq_b.push_back('{a, v, cyc + 1});
      tick();
      sv  = 1'b0;
      smp = '1;
   endtask

   task automatic gap();
      sv  = 1'b0;
      smp = '1;
      tick();
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp);
      rd_req  = 1'b1;
      rd_addr = a;
      rq_a.push_back('{exp, cyc + 3});
      rq_b.push_back('{exp, cyc + 2});
      tick();
      rd_req = 1'b0;
   endtask

   task automatic status(input string nm, input logic b, input logic f);
      chk({nm, " busy_a"}, busy_a, b);
      chk({nm, " full_a"}, full_a, f);
      chk({nm, " busy_b"}, busy_b, b);
      chk({nm, " full_b"}, full_b, f);
   endtask

   task automatic rst_vals(input string nm);
      chk({nm, " busy"},   {busy_a, busy_b}, 0);
      chk({nm, " full"},   {full_a, full_b}, 0);
      chk({nm, " valid"},  {vld_a, vld_b}, 0);
      chk({nm, " ena"},    {ena_a, ena_b}, 0);
      chk({nm, " wea"},    {wea_a, wea_b}, 0);
      chk({nm, " regcea"}, {regcea_a, regcea_b}, 0);
      chk({nm, " rsta"},   {rsta_a, rsta_b}, 2'b11);
      chk({nm, " addr"},   {addr_a, addr_b}, 0);
      chk({nm, " din_a"},  din_a, 0);
      chk({nm, " din_b"},  din_b, 0);
   endtask

   initial begin
      repeat (3) tick();
      rst_vals("por");
      rst = 1'b0;
      tick();

      // sequential capture of 1..16
      pulse_run();
      status("t1 capture", 1, 0);
      for (int i = 0; i < D; i++) wr(W'(i + 1), AW'(i));
      status("t1 done", 0, 1);

      // back-to-back reads
      rd(4'd3, 18'h00004);
      rd(4'd4, 18'h00005);
      rd(4'd15, 18'h00010);
      repeat (5) tick();

      // capture with alternating gaps
      pulse_run();
      for (int k = 0; k < 2 * D; k++) begin
         if (k % 2 == 0) wr(W'(18'h100 + k / 2), AW'(k / 2));
         else            gap();
      end
      status("t2 done", 0, 1);
      rd(4'd0, 18'h00100);
      rd(4'd7, 18'h00107);
      rd(4'd15, 18'h0010F);
      repeat (5) tick();

      // read in flight, then run and read together: read dropped, capture restarts
      rd(4'd5, 18'h00105);
      run = 1'b1; rd_req = 1'b1; rd_addr = 4'd2;
      tick();
      run = 1'b0; rd_req = 1'b0;
      status("t6 restart", 1, 0);
      for (int i = 0; i < 5; i++) wr(W'(18'h200 + i), AW'(i));

      // async reset right after the 5th write reaches the pins
      #2 rst = 1'b1;
      #1 rst_vals("mid reset");
      repeat (2) tick();
      rst = 1'b0;
      tick();

      pulse_run();
      for (int i = 0; i < D; i++) wr(W'(18'h300 + i), AW'(i));
      status("t5 done", 0, 1);
      rd(4'd0, 18'h00300);
      rd(4'd15, 18'h0030F);
      repeat (6) tick();

      chk("wq_a drained", wq_a.size(), 0);
      chk("wq_b drained", wq_b.size(), 0);
      chk("rq_a drained", rq_a.size(), 0);
      chk("rq_b drained", rq_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
